// File: rtl/lenet_buf_pkg.sv
// Shared sizing helpers and the depth clamp for the LeNet delay-line buffers.
package lenet_buf_pkg;

   localparam int unsigned LB_DEF_MAX_DEPTH = 32;
   localparam int unsigned LB_DEF_PTR_W     = $clog2(LB_DEF_MAX_DEPTH);

   // A one-entry buffer still needs a one-bit pointer so the port exists.
   function automatic int unsigned ptr_width(input int unsigned max_depth);
      return (max_depth > 1) ? $clog2(max_depth) : 1;
   endfunction

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      if (len == 0) return 1;
      if (len > max_len) return max_len;
      return len;
   endfunction

   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/circ_buf_ram.sv
// Storage for the delay line: one synchronous write port, one combinational read port, no reset.
module circ_buf_ram
   import lenet_buf_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = LB_DEF_MAX_DEPTH,
   parameter int unsigned ADDR_W = LB_DEF_PTR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/prog_depth_shift_buffer.sv
// Multi-lane delay line with runtime-programmable depth, fill tracking and an output-valid flag.
module prog_depth_shift_buffer
   import lenet_buf_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CH        = 1,
   parameter int unsigned MAX_DEPTH = LB_DEF_MAX_DEPTH,
   parameter int unsigned LEN_W     = 6
) (
   input  logic                clk,
   input  logic                global_rst,
   input  logic                rst,
   input  logic                ce,
   input  logic [LEN_W-1:0]    i_len,
   input  logic [CH*WIDTH-1:0] i_data,
   output logic [CH*WIDTH-1:0] o_data,
   output logic                o_valid,
   output logic [LEN_W-1:0]    o_fill
);

   localparam int unsigned PTR_W = ptr_width(MAX_DEPTH);
   localparam int unsigned DW    = CH * WIDTH;

   logic [LEN_W-1:0] len_eff;
   logic [LEN_W-1:0] len_q, len_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic             valid_q, valid_d;
   logic [DW-1:0]    data_q, data_d;
   logic             ram_we;
   logic [DW-1:0]    ram_rdata;

   assign len_eff = LEN_W'(clamp_len(32'(i_len), MAX_DEPTH));

   circ_buf_ram #(
      .DATA_W (DW),
      .DEPTH  (MAX_DEPTH),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ptr_q),
      .wdata (i_data),
      .raddr (ptr_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      len_d   = len_q;
      ptr_d   = ptr_q;
      fill_d  = fill_q;
      valid_d = valid_q;
      data_d  = data_q;
      ram_we  = 1'b0;
      if (rst) begin
         ptr_d   = '0;
         fill_d  = '0;
         valid_d = 1'b0;
         data_d  = '0;
      end else if (len_eff != len_q) begin
         // Old contents belong to the previous depth; drop them and this cycle's sample.
         len_d   = len_eff;
         ptr_d   = '0;
         fill_d  = '0;
         valid_d = 1'b0;
         data_d  = '0;
      end else if (ce) begin
         ram_we  = 1'b1;
         for (int unsigned k = 0; k < CH; k++) begin
            data_d[lane_lsb(k, WIDTH) +: WIDTH] = ram_rdata[lane_lsb(k, WIDTH) +: WIDTH];
         end
         valid_d = (fill_q == len_q);
         fill_d  = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
         ptr_d   = (LEN_W'(ptr_q) == len_q - LEN_W'(1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   // Depth is captured from the live input during reset so a restart needs no extra flush.
   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         len_q   <= len_eff;
         ptr_q   <= '0;
         fill_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         fill_q  <= fill_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_fill  = fill_q;

endmodule

// File: tb/tb_prog_depth_shift_buffer.sv
// Directed bench for prog_depth_shift_buffer with two lanes and MAX_DEPTH=32.
module tb_prog_depth_shift_buffer;

   logic        clk;
   logic        global_rst;
   logic        rst;
   logic        ce;
   logic [5:0]  i_len;
   logic [15:0] i_data;
   logic [15:0] o_data;
   logic        o_valid;
   logic [5:0]  o_fill;

   int checks;
   int errors;

   prog_depth_shift_buffer #(
      .WIDTH     (8),
      .CH        (2),
      .MAX_DEPTH (32),
      .LEN_W     (6)
   ) dut (
      .clk        (clk),
      .global_rst (global_rst),
      .rst        (rst),
      .ce         (ce),
      .i_len      (i_len),
      .i_data     (i_data),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_fill     (o_fill)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] pack(input int l0, input int l1);
      logic [7:0] a;
      logic [7:0] b;
      a = 8'(l0);
      b = 8'(l1);
      return {b, a};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic c, input logic [15:0] d);
      ce     = c;
      i_data = d;
      @(posedge clk);
      #1;
   endtask

   // Continuous ce stream of samples k=1..n (lane0=k, lane1=-k) at depth len.
   task automatic run_stream(input string tag, input int n, input int len);
      int fexp;
      for (int k = 1; k <= n; k++) begin
         tick(1'b1, pack(k, -k));
         fexp = (k < len) ? k : len;
         check({tag, "_valid"}, 32'(o_valid), 32'(k > len));
         check({tag, "_fill"}, 32'(o_fill), 32'(fexp));
         if (k > len) check({tag, "_data"}, 32'(o_data), 32'(pack(k - len, -(k - len))));
      end
   endtask

   initial begin
      int         adv;
      logic       ev;
      int         ef;
      logic [15:0] ed;

      checks     = 0;
      errors     = 0;
      global_rst = 1'b1;
      rst        = 1'b0;
      ce         = 1'b0;
      i_len      = 6'd4;
      i_data     = '0;
      #1;
      check("reset_data", 32'(o_data), 32'h0);
      check("reset_valid", 32'(o_valid), 32'h0);
      check("reset_fill", 32'(o_fill), 32'h0);
      #2 global_rst = 1'b0;
      tick(1'b0, 16'h0);
      check("idle_fill", 32'(o_fill), 32'h0);

      // Depth 4 continuous stream: valid on the 5th edge with (1,-1).
      run_stream("len4", 10, 4);

      // Async reset between edges clears outputs immediately.
      #2 global_rst = 1'b1;
      #1;
      check("grst_data", 32'(o_data), 32'h0);
      check("grst_valid", 32'(o_valid), 32'h0);
      check("grst_fill", 32'(o_fill), 32'h0);
      #1 global_rst = 1'b0;
      run_stream("restart", 6, 4);

      // Sync flush together with ce while valid: flush wins.
      rst = 1'b1;
      tick(1'b1, pack(99, -99));
      rst = 1'b0;
      check("rst_ce_valid", 32'(o_valid), 32'h0);
      check("rst_ce_fill", 32'(o_fill), 32'h0);
      check("rst_ce_data", 32'(o_data), 32'h0);

      // Same stream with ce toggling: outputs identical, only spaced out.
      adv = 0;
      ev  = 1'b0;
      ef  = 0;
      ed  = 16'h0;
      for (int j = 1; j <= 20; j++) begin
         if (j % 2 == 1) begin
            adv++;
            tick(1'b1, pack(adv, -adv));
            ev = (adv > 4);
            ef = (adv < 4) ? adv : 4;
            if (ev) ed = pack(adv - 4, -(adv - 4));
         end else begin
            tick(1'b0, pack(77, -77));
         end
         check("bubble_valid", 32'(o_valid), 32'(ev));
         check("bubble_fill", 32'(o_fill), 32'(ef));
         if (ev) check("bubble_data", 32'(o_data), 32'(ed));
      end

      // Depth change 4->6 while valid with ce high: flush and drop that sample.
      i_len = 6'd6;
      tick(1'b1, pack(55, -55));
      check("chg_valid", 32'(o_valid), 32'h0);
      check("chg_fill", 32'(o_fill), 32'h0);
      run_stream("len6", 9, 6);

      // i_len=0 clamps to a one-advance delay.
      i_len = 6'd0;
      tick(1'b0, 16'h0);
      check("len0_flush_fill", 32'(o_fill), 32'h0);
      check("len0_flush_valid", 32'(o_valid), 32'h0);
      run_stream("len0", 5, 1);

      // i_len=40 clamps to MAX_DEPTH=32.
      i_len = 6'd40;
      tick(1'b0, 16'h0);
      check("len40_flush_fill", 32'(o_fill), 32'h0);
      run_stream("len40", 35, 32);

      // ce low holds everything including valid.
      tick(1'b0, pack(1, 1));
      check("hold_valid", 32'(o_valid), 32'h1);
      check("hold_fill", 32'(o_fill), 32'd32);
      check("hold_data", 32'(o_data), 32'(pack(3, -3)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
